conv_bram_1d_ctrl: RTL and testbench
====================================

CONV_BRAM_1D_CTRL -- requirements
Module: conv_bram_1d_ctrl

Interface
REQ-001 Parameter IMG_W, default 32: image width in columns.
REQ-002 Parameter FILTER_L, default 3: filter length in columns.
REQ-003 Parameter STRIDE_W, default 1: column stride between output windows.
REQ-004 Parameter IMG_RD_LATENCY, default 1: image BRAM read latency in cycles, rden to valid rddata; legal range 1..4.
REQ-005 Derived constants: RESULT_W = (IMG_W-FILTER_L)/STRIDE_W+1; LAST_COL = (RESULT_W-1)*STRIDE_W+FILTER_L-1; IMG_RAM_ADDR_WIDTH = $clog2(IMG_W); RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to begin one convolution pass.
REQ-009 busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-010 done  output  1  one-cycle pulse marking pass completion.
REQ-011 img_rden  output  1  image BRAM read enable.
REQ-012 img_rdaddr  output  IMG_RAM_ADDR_WIDTH  image BRAM column address.
REQ-013 dpath_sr_wren  output  1  window shift-register enable to the datapath.
REQ-014 dpath_result_wraddr  output  RESULT_RAM_ADDR_WIDTH  output column index to the datapath.
REQ-015 dpath_result_wren  output  1  valid window-to-MAC strobe to the datapath.
REQ-016 last_val  input  1  datapath flag: final result has been written.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, DONE; all outputs are registered.
REQ-018 IDLE: start=1 at an edge moves the FSM to READ; start is ignored in every other state.
REQ-019 READ: img_rden=1 every cycle; img_rdaddr = 0,1,...,LAST_COL on consecutive cycles; columns above LAST_COL are never read.
REQ-020 The FSM moves from READ to DRAIN on the edge following the cycle that issues img_rdaddr=LAST_COL.
REQ-021 dpath_sr_wren equals img_rden delayed by exactly IMG_RD_LATENCY cycles, using a shift chain.
REQ-022 A column counter increments on each dpath_sr_wren cycle; it resets to 0 on pass start.
REQ-023 When the column counter value c satisfies c >= FILTER_L-1 and (c-(FILTER_L-1)) mod STRIDE_W == 0, dpath_result_wren=1 the cycle after that sr_wren.
REQ-024 Each such dpath_result_wren cycle carries dpath_result_wraddr = w, counting 0..RESULT_W-1.
REQ-025 The stride test uses a phase counter that wraps at STRIDE_W; no divider or modulo hardware is permitted.
REQ-026 Exactly RESULT_W dpath_result_wren pulses occur per pass.
REQ-027 dpath_result_wraddr holds its last value while dpath_result_wren=0.
REQ-028 DRAIN: the FSM waits for last_val=1, then moves to DONE; last_val in any other state is ignored.
REQ-029 DONE lasts one cycle with done=1 and busy=1, then the FSM returns to IDLE; start in that cycle is ignored.
REQ-030 Latency: with start accepted at edge k, img_rdaddr=0 is issued in cycle k+1; the first dpath_result_wren occurs in cycle k+FILTER_L+IMG_RD_LATENCY+1.

Reset
REQ-031 reset=0 asynchronously forces IDLE and clears all counters and delay chains.
REQ-032 During reset, outputs are busy=0, done=0, img_rden=0, img_rdaddr=0, dpath_sr_wren=0, dpath_result_wren=0, dpath_result_wraddr=0.
REQ-033 Reset asserted mid-pass aborts the pass; no further strobes are issued, including those already in delay chains.

Structure
REQ-034 The FSM state enum and the RESULT_W/LAST_COL calculation functions belong in shared package conv_1d_pkg.
REQ-035 The rden-to-sr_wren delay is one sub-module, conv_1d_ctrl_delay, parameterised by width and depth.

Verification
REQ-036 IMG_W=8, FILTER_L=3, STRIDE_W=1, LAT=1, start at edge 0 -> rdaddr 0..7 in cycles 1..8; result_wren in cycles 5..10 with wraddr 0..5.
REQ-037 IMG_W=9, FILTER_L=3, STRIDE_W=2 -> 4 results, wraddr 0..3 from columns 2, 4, 6, 8.
REQ-038 IMG_W=8, FILTER_L=3, STRIDE_W=2 -> rdaddr 0..6 only, column 7 never read; 3 results.
REQ-039 LAT=3, IMG_W=8, FILTER_L=3 -> sr_wren lags rden by exactly 3 cycles; first result_wren in cycle 7.
REQ-040 last_val driven 4 cycles after the final result_wren -> done pulses one cycle after last_val and busy then drops; start pulses during the pass and during DONE are ignored.
REQ-041 reset=0 for one cycle mid-READ -> all outputs 0 immediately and no stray strobes; the next start runs a full correct pass.

Source files
------------

// File: rtl/conv_1d_pkg.sv
// ----------------------------------------------------------------------------
// conv_1d_pkg
// Shared definitions for the 1-D convolution BRAM controller:
//   state_t        - controller FSM states
//   calc_result_w  - number of output windows for an image/filter/stride
//   calc_last_col  - last image column touched by the final window
//   addr_w         - address width for a memory of n entries (never below 1)
// ----------------------------------------------------------------------------
package conv_1d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_result_w(input int img_w, input int filter_l,
                                         input int stride_w);
        return (img_w - filter_l) / stride_w + 1;
    endfunction

    function automatic int calc_last_col(input int img_w, input int filter_l,
                                         input int stride_w);
        return (calc_result_w(img_w, filter_l, stride_w) - 1) * stride_w
               + filter_l - 1;
    endfunction

    // A single-entry memory still needs a 1-bit address port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_1d_ctrl_delay.sv
// ----------------------------------------------------------------------------
// conv_1d_ctrl_delay
// Fixed-depth register chain: dout is din delayed by exactly DEPTH cycles.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset, clears every stage
//   din    - WIDTH-bit input
//   dout   - WIDTH-bit output, din from DEPTH cycles earlier
// ----------------------------------------------------------------------------
module conv_1d_ctrl_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// ----------------------------------------------------------------------------
// conv_bram_1d_ctrl
// Sequences one 1-D convolution pass: streams image columns 0..LAST_COL out of
// the image BRAM, re-times the read enable to the BRAM latency to feed the
// datapath window shift register, and flags every column that completes a
// strided window so the datapath can write a result.
// Ports:
//   clk                 - clock
//   reset               - asynchronous active-low reset
//   start               - one-cycle pass request (honoured only when idle)
//   busy                - pass in progress, through the done cycle
//   done                - one-cycle completion pulse
//   img_rden/img_rdaddr - image BRAM read port
//   dpath_sr_wren       - window shift-register enable (rden delayed)
//   dpath_result_wren   - window complete, write result
//   dpath_result_wraddr - output column index for the result
//   last_val            - datapath reports the final result is written
// ----------------------------------------------------------------------------
module conv_bram_1d_ctrl
    import conv_1d_pkg::*;
#(
    parameter int IMG_W          = 32,
    parameter int FILTER_L       = 3,
    parameter int STRIDE_W       = 1,
    parameter int IMG_RD_LATENCY = 1,
    localparam int RESULT_W              = calc_result_w(IMG_W, FILTER_L, STRIDE_W),
    localparam int LAST_COL              = calc_last_col(IMG_W, FILTER_L, STRIDE_W),
    localparam int IMG_RAM_ADDR_WIDTH    = addr_w(IMG_W),
    localparam int RESULT_RAM_ADDR_WIDTH = addr_w(RESULT_W)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             img_rden,
    output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
    output logic                             dpath_sr_wren,
    output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
    output logic                             dpath_result_wren,
    input  logic                             last_val
);

    localparam int IA = IMG_RAM_ADDR_WIDTH;
    localparam int RA = RESULT_RAM_ADDR_WIDTH;
    // One spare bit so the column counter never wraps inside a pass.
    localparam int CW = $clog2(IMG_W) + 1;
    localparam int PW = (STRIDE_W > 1) ? $clog2(STRIDE_W) : 1;

    localparam logic [IA-1:0] LAST_ADDR  = IA'(LAST_COL);
    localparam logic [CW-1:0] FIRST_WIN  = CW'(FILTER_L - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(STRIDE_W - 1);

    // ------------------------------------------------------------------
    // Control FSM. Every output is registered from the next-state values,
    // so outputs change together with the state they belong to.
    // ------------------------------------------------------------------
    state_t          state, state_nxt;
    logic [IA-1:0]   rdaddr_nxt;
    logic            busy_nxt, done_nxt, rden_nxt;
    logic            pass_start;

    always_comb begin
        state_nxt  = state;
        rdaddr_nxt = img_rdaddr;
        pass_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = READ;
                    rdaddr_nxt = '0;
                    pass_start = 1'b1;
                end
            end
            READ: begin
                if (img_rdaddr == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end else begin
                    rdaddr_nxt = img_rdaddr + 1'b1;
                end
            end
            DRAIN: begin
                if (last_val) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        rden_nxt = (state_nxt == READ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            img_rden   <= 1'b0;
            img_rdaddr <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            img_rden   <= rden_nxt;
            img_rdaddr <= rdaddr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read data arrives IMG_RD_LATENCY cycles after rden; the shift
    // register enable follows it exactly.
    // ------------------------------------------------------------------
    conv_1d_ctrl_delay #(
        .WIDTH (1),
        .DEPTH (IMG_RD_LATENCY)
    ) u_rden_dly (
        .clk   (clk),
        .reset (reset),
        .din   (img_rden),
        .dout  (dpath_sr_wren)
    );

    // ------------------------------------------------------------------
    // Window tracking. col counts columns shifted into the window; once
    // the window is full, phase walks 0..STRIDE_W-1 and a window is
    // complete whenever phase is 0, which replaces a modulo on col.
    // ------------------------------------------------------------------
    logic [CW-1:0] col;
    logic [PW-1:0] phase;
    logic [RA-1:0] res_cnt;
    logic          win_full, win_hit;

    assign win_full = (col >= FIRST_WIN);
    assign win_hit  = dpath_sr_wren && win_full && (phase == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col                 <= '0;
            phase               <= '0;
            res_cnt             <= '0;
            dpath_result_wren   <= 1'b0;
            dpath_result_wraddr <= '0;
        end else begin
            dpath_result_wren <= win_hit;
            if (pass_start) begin
                col     <= '0;
                phase   <= '0;
                res_cnt <= '0;
            end else if (dpath_sr_wren) begin
                col <= col + 1'b1;
                if (win_full) begin
                    phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
                end
                if (win_hit) begin
                    res_cnt <= res_cnt + 1'b1;
                end
            end
            // wraddr only moves with a strobe and holds otherwise.
            if (win_hit) begin
                dpath_result_wraddr <= res_cnt;
            end
        end
    end

endmodule

// File: tb/tb_conv_bram_1d_ctrl.sv
module tb_conv_bram_1d_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] start, last_val;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Four configurations: {W,L,S,LAT}
    int cfg_w[4]   = '{8, 9, 8, 8};
    int cfg_l[4]   = '{3, 3, 3, 3};
    int cfg_s[4]   = '{1, 2, 2, 1};
    int cfg_lat[4] = '{1, 1, 1, 3};

    logic [3:0] busy_v, done_v, rden_v, srw_v, rw_v;
    logic [3:0][3:0] addr_v, wa_v;
    logic [2:0] a0, a2, a3, w0, w3;
    logic [3:0] a1;
    logic [1:0] w1, w2;

    assign addr_v[0] = {1'b0, a0};
    assign addr_v[1] = a1;
    assign addr_v[2] = {1'b0, a2};
    assign addr_v[3] = {1'b0, a3};
    assign wa_v[0]   = {1'b0, w0};
    assign wa_v[1]   = {2'b0, w1};
    assign wa_v[2]   = {2'b0, w2};
    assign wa_v[3]   = {1'b0, w3};

    conv_bram_1d_ctrl #(.IMG_W(8), .FILTER_L(3), .STRIDE_W(1), .IMG_RD_LATENCY(1)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy_v[0]), .done(done_v[0]),
        .img_rden(rden_v[0]), .img_rdaddr(a0), .dpath_sr_wren(srw_v[0]),
        .dpath_result_wraddr(w0), .dpath_result_wren(rw_v[0]), .last_val(last_val[0]));
    conv_bram_1d_ctrl #(.IMG_W(9), .FILTER_L(3), .STRIDE_W(2), .IMG_RD_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy_v[1]), .done(done_v[1]),
        .img_rden(rden_v[1]), .img_rdaddr(a1), .dpath_sr_wren(srw_v[1]),
        .dpath_result_wraddr(w1), .dpath_result_wren(rw_v[1]), .last_val(last_val[1]));
    conv_bram_1d_ctrl #(.IMG_W(8), .FILTER_L(3), .STRIDE_W(2), .IMG_RD_LATENCY(1)) u2 (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy_v[2]), .done(done_v[2]),
        .img_rden(rden_v[2]), .img_rdaddr(a2), .dpath_sr_wren(srw_v[2]),
        .dpath_result_wraddr(w2), .dpath_result_wren(rw_v[2]), .last_val(last_val[2]));
    conv_bram_1d_ctrl #(.IMG_W(8), .FILTER_L(3), .STRIDE_W(1), .IMG_RD_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .start(start[3]), .busy(busy_v[3]), .done(done_v[3]),
        .img_rden(rden_v[3]), .img_rdaddr(a3), .dpath_sr_wren(srw_v[3]),
        .dpath_result_wraddr(w3), .dpath_result_wren(rw_v[3]), .last_val(last_val[3]));

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t rd_q[$], sr_q[$], res_q[$];
    int  checks = 0, errors = 0;
    int  sel = 0;
    bit  mon_en = 1'b0, pass_act = 1'b0;
    int  busy_from = 0, busy_to = 0;
    int  exp_wa[4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected event schedule for one pass on instance i, start accepted at edge k.
    task automatic plan_pass(input int i, input int k, output int f);
        int w, last;
        ev_t ev;
        w = 0;
        last = 0;
        for (int c = 0; c < cfg_w[i]; c++) begin
            if (c >= cfg_l[i] - 1 && (c - (cfg_l[i] - 1)) % cfg_s[i] == 0) begin
                ev.cyc = k + 2 + c + cfg_lat[i];
                ev.val = w;
                res_q.push_back(ev);
                w++;
                last = c;
            end
        end
        for (int c = 0; c <= last; c++) begin
            ev.cyc = k + 1 + c;
            ev.val = c;
            rd_q.push_back(ev);
            ev.cyc = k + 1 + c + cfg_lat[i];
            sr_q.push_back(ev);
        end
        f         = k + 2 + last + cfg_lat[i];
        busy_from = k + 1;
        busy_to   = f + 5;
        pass_act  = 1'b1;
    endtask

    // Monitor: compares DUT strobes against the queued expectations.
    initial begin
        ev_t e;
        logic [3:0] m;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                m = ~(4'b0001 << sel);
                chk("quiet", (busy_v | done_v | rden_v | srw_v | rw_v) & m, 0);
                if (rden_v[sel]) begin
                    if (rd_q.size() == 0) chk("rd_extra", 1, 0);
                    else begin
                        e = rd_q.pop_front();
                        chk("rd_cyc", cyc, e.cyc);
                        chk("rd_addr", addr_v[sel], e.val);
                    end
                end
                if (srw_v[sel]) begin
                    if (sr_q.size() == 0) chk("sr_extra", 1, 0);
                    else begin
                        e = sr_q.pop_front();
                        chk("sr_cyc", cyc, e.cyc);
                    end
                end
                if (rw_v[sel]) begin
                    if (res_q.size() == 0) chk("res_extra", 1, 0);
                    else begin
                        e = res_q.pop_front();
                        chk("res_cyc", cyc, e.cyc);
                        chk("res_addr", wa_v[sel], e.val);
                        exp_wa[sel] = e.val;
                    end
                end else begin
                    chk("wa_hold", wa_v[sel], exp_wa[sel]);
                end
                chk("busy", busy_v[sel], pass_act && cyc >= busy_from && cyc <= busy_to);
                chk("done", done_v[sel], pass_act && cyc == busy_to);
            end
        end
    end

    task automatic run_pass(input int i, input bit extra);
        int k, f;
        sel = i;
        k = cyc;
        plan_pass(i, k, f);
        start[i] = 1'b1;
        @(posedge clk); #1;
        while (cyc < f + 4) begin
            // stray start during the pass and last_val during READ must be ignored
            start[i]    = extra && (cyc == k + 3);
            last_val[i] = extra && (cyc == k + 2);
            @(posedge clk); #1;
        end
        start[i]    = 1'b0;
        last_val[i] = 1'b1;
        @(posedge clk); #1;
        last_val[i] = 1'b0;
        start[i]    = extra;   // lands in the DONE cycle
        @(posedge clk); #1;
        start[i]    = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rd_left", rd_q.size(), 0);
        chk("sr_left", sr_q.size(), 0);
        chk("res_left", res_q.size(), 0);
        pass_act = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy_v, 0);
        chk({tag, "_done"}, done_v, 0);
        chk({tag, "_rden"}, rden_v, 0);
        chk({tag, "_addr"}, addr_v, 0);
        chk({tag, "_srw"}, srw_v, 0);
        chk({tag, "_rw"}, rw_v, 0);
        chk({tag, "_wa"}, wa_v, 0);
    endtask

    initial begin
        int k, f;
        reset    = 1'b0;
        start    = '0;
        last_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        run_pass(0, 1'b1);
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);
        run_pass(3, 1'b1);

        // Abort mid-READ with a one-cycle reset pulse.
        sel = 0;
        k = cyc;
        plan_pass(0, k, f);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        while (cyc < k + 4) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        rd_q.delete();
        sr_q.delete();
        res_q.delete();
        pass_act = 1'b0;
        exp_wa   = '{0, 0, 0, 0};
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        run_pass(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
